tspi_frame_sequencer: RTL and testbench



---
 rtl/tspi_pkg.sv | 18 +
 rtl/tspi_frame_sequencer_counter.sv | 20 ++
 rtl/tspi_frame_sequencer.sv | 147 ++++++++++++++
 tb/tb_tspi_frame_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tspi_pkg.sv
// Shared types for the TSPI frame sequencer: FSM state encoding and command record.
package tspi_pkg;

  localparam int TSPI_LEN_W = 6;
  localparam int TSPI_REP_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } tspi_seq_state_e;

  typedef struct packed {
    logic [TSPI_LEN_W-1:0] len;
    logic [TSPI_REP_W-1:0] rep;
  } tspi_seq_cmd_t;

endpackage

// File: rtl/tspi_frame_sequencer_counter.sv
// Up-counter with synchronous clear (clear wins over enable); tracks the bit index within a frame.
module tspi_frame_sequencer_counter #(
  parameter int WIDTH = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] q_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      q_o <= '0;
    end else if (en_i) begin
      q_o <= q_o + WIDTH'(1);
    end
  end

endmodule

// File: rtl/tspi_frame_sequencer.sv
// TSPI frame sequencer: bit/frame counting per {len,rep} command with one pending slot.
// Optional abort path enabled by defining TSPI_SEQ_ABORT_EN.
module tspi_frame_sequencer
  import tspi_pkg::*;
#(
  parameter int LEN_WIDTH = TSPI_LEN_W,
  parameter int REP_WIDTH = TSPI_REP_W,
  parameter int GAP_BITS  = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 bit_tick_i,
`ifdef TSPI_SEQ_ABORT_EN
  input  logic                 abort_i,
  output logic                 aborted_o,
`endif
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [LEN_WIDTH-1:0] cmd_len_i,
  input  logic [REP_WIDTH-1:0] cmd_rep_i,
  output logic                 busy_o,
  output logic [LEN_WIDTH-1:0] bit_idx_o,
  output logic [REP_WIDTH-1:0] rep_o,
  output logic                 first_bit_o,
  output logic                 last_bit_o,
  output logic                 frame_done_o,
  output logic                 cmd_done_o
);

  // Handshake: a command transfers on a cycle where cmd_valid_i & cmd_ready_o; ready depends only
  // on the pending slot being empty (and no abort), never on cmd_valid_i.

  typedef struct packed {
    logic [LEN_WIDTH-1:0] len;
    logic [REP_WIDTH-1:0] rep;
  } cmd_t;

  localparam int GAP_W = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

  tspi_seq_state_e state_q, state_d;
  cmd_t            act_q, pend_q, cmd_in;
  logic            pend_valid_q;
  logic [GAP_W-1:0] gap_q;
  logic [LEN_WIDTH-1:0] bit_idx;

  logic abort, accept, run, last_bit, frame_end, cmd_end;
  logic idle_load, chain_load, gap_end;

`ifdef TSPI_SEQ_ABORT_EN
  logic aborted_q;
  assign abort = abort_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) aborted_q <= 1'b0;
    else       aborted_q <= abort_i;
  end
  assign aborted_o = aborted_q;
`else
  assign abort = 1'b0;
`endif

  assign cmd_in      = '{len: cmd_len_i, rep: cmd_rep_i};
  assign cmd_ready_o = !pend_valid_q && !abort;
  assign accept      = cmd_valid_i && cmd_ready_o;
  assign run         = (state_q == RUN);
  assign last_bit    = run && (bit_idx == act_q.len);
  assign frame_end   = last_bit && bit_tick_i && !abort;
  assign cmd_end     = frame_end && (act_q.rep == '0);
  assign idle_load   = (state_q == IDLE) && accept;
  // Next command follows without an IDLE cycle: from the pending slot, or straight from the port.
  assign chain_load  = cmd_end && (pend_valid_q || accept);
  assign gap_end     = (state_q == GAP) && bit_tick_i && (gap_q == GAP_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = RUN;
      RUN: begin
        if (cmd_end) begin
          if (chain_load) state_d = (GAP_BITS > 0) ? GAP : RUN;
          else            state_d = IDLE;
        end
      end
      GAP: if (gap_end) state_d = RUN;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  always_comb begin
    busy_o       = (state_q != IDLE);
    first_bit_o  = run && (bit_idx == '0);
    last_bit_o   = last_bit;
    frame_done_o = frame_end;
    cmd_done_o   = cmd_end;
    bit_idx_o    = bit_idx;
    rep_o        = act_q.rep;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      act_q        <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      gap_q        <= '0;
    end else if (abort) begin
      act_q        <= '0;
      pend_valid_q <= 1'b0;
      gap_q        <= '0;
    end else begin
      if (idle_load) begin
        act_q <= cmd_in;
      end else if (chain_load) begin
        act_q <= pend_valid_q ? pend_q : cmd_in;
      end else if (frame_end) begin
        act_q.rep <= act_q.rep - REP_WIDTH'(1);
      end

      if (chain_load) begin
        pend_valid_q <= 1'b0;
      end else if (accept && (state_q != IDLE)) begin
        pend_q       <= cmd_in;
        pend_valid_q <= 1'b1;
      end

      if (state_q != GAP)  gap_q <= '0;
      else if (bit_tick_i) gap_q <= gap_end ? '0 : gap_q + GAP_W'(1);
    end
  end

  tspi_frame_sequencer_counter #(
    .WIDTH (LEN_WIDTH)
  ) u_bit_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (frame_end || idle_load || abort),
    .en_i    (run && bit_tick_i && !last_bit && !abort),
    .q_o     (bit_idx)
  );

endmodule

// File: tb/tb_tspi_frame_sequencer.sv
// Directed bench for tspi_frame_sequencer: one instance back-to-back (GAP_BITS=0), one with GAP_BITS=2.
module tb_tspi_frame_sequencer;

  logic       clk = 1'b0;
  logic       rst, bit_tick, cmd_valid, abort;
  logic [5:0] cmd_len;
  logic [7:0] cmd_rep;

  logic       ready, busy, first_bit, last_bit, frame_done, cmd_done, aborted;
  logic [5:0] bit_idx;
  logic [7:0] rep;
  logic       g_ready, g_busy, g_first, g_last, g_frame_done, g_cmd_done, g_aborted;
  logic [5:0] g_idx;
  logic [7:0] g_rep;

  int n_checks = 0;
  int n_fail   = 0;
  int fd_cnt, cd_cnt, last_c, gap_ticks;

  always #5 clk = ~clk;

  tspi_frame_sequencer #(.LEN_WIDTH(6), .REP_WIDTH(8), .GAP_BITS(0)) dut (
    .clk_i(clk), .rst_i(rst), .bit_tick_i(bit_tick),
`ifdef TSPI_SEQ_ABORT_EN
    .abort_i(abort), .aborted_o(aborted),
`endif
    .cmd_valid_i(cmd_valid), .cmd_ready_o(ready), .cmd_len_i(cmd_len), .cmd_rep_i(cmd_rep),
    .busy_o(busy), .bit_idx_o(bit_idx), .rep_o(rep), .first_bit_o(first_bit),
    .last_bit_o(last_bit), .frame_done_o(frame_done), .cmd_done_o(cmd_done)
  );

  tspi_frame_sequencer #(.LEN_WIDTH(6), .REP_WIDTH(8), .GAP_BITS(2)) dut_gap (
    .clk_i(clk), .rst_i(rst), .bit_tick_i(bit_tick),
`ifdef TSPI_SEQ_ABORT_EN
    .abort_i(abort), .aborted_o(g_aborted),
`endif
    .cmd_valid_i(cmd_valid), .cmd_ready_o(g_ready), .cmd_len_i(cmd_len), .cmd_rep_i(cmd_rep),
    .busy_o(g_busy), .bit_idx_o(g_idx), .rep_o(g_rep), .first_bit_o(g_first),
    .last_bit_o(g_last), .frame_done_o(g_frame_done), .cmd_done_o(g_cmd_done)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic [5:0] len, input logic [7:0] r);
    cmd_valid = 1'b1;
    cmd_len   = len;
    cmd_rep   = r;
  endtask

  task automatic drain();
    bit_tick  = 1'b1;
    cmd_valid = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!busy && !g_busy) break;
      cyc();
    end
    check("drain_idle", {30'd0, busy, g_busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; bit_tick = 1'b1; cmd_valid = 1'b0; cmd_len = '0; cmd_rep = '0; abort = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_ready", ready, 1);
    check("rst_idx", bit_idx, 0);
    check("rst_rep", rep, 0);
    check("rst_first", first_bit, 0);
    check("rst_last", last_bit, 0);
    check("rst_fdone", frame_done, 0);
    check("rst_cdone", cmd_done, 0);
    cyc();
    check("idle_tick_idx", bit_idx, 0);
    check("idle_tick_busy", busy, 0);

    // Single command len=7 rep=0, tick every cycle
    offer(6'd7, 8'd0);
    cyc();
    cmd_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("t1_idx", bit_idx, i);
      check("t1_first", first_bit, (i == 0));
      check("t1_last", last_bit, (i == 7));
      check("t1_fdone", frame_done, (i == 7));
      check("t1_cdone", cmd_done, (i == 7));
      cyc();
    end
    check("t1_idle", busy, 0);
    drain();

    // len=3 rep=2, tick every 4th cycle
    bit_tick = 1'b0;
    offer(6'd3, 8'd2);
    cyc();
    cmd_valid = 1'b0;
    fd_cnt = 0; cd_cnt = 0; last_c = 0;
    for (int c = 0; c < 80; c++) begin
      bit_tick = ((c % 4) == 3);
      #1;
      if (frame_done) begin
        check("t2_rep", rep, 2 - fd_cnt);
        if (fd_cnt > 0) check("t2_spacing", c - last_c, 16);
        last_c = c;
        fd_cnt++;
      end
      if (cmd_done) begin
        cd_cnt++;
        check("t2_cd_rep", rep, 0);
      end
      cyc();
      if (!busy) break;
    end
    check("t2_frames", fd_cnt, 3);
    check("t2_cmds", cd_cnt, 1);
    check("t2_idle", busy, 0);
    drain();

    // Back-to-back, GAP_BITS=0
    offer(6'd1, 8'd0);
    cyc();
    offer(6'd2, 8'd0);
    #1;
    check("t3_ready_free", ready, 1);
    cyc();
    cmd_valid = 1'b0;
    #1;
    check("t3_ready_pend", ready, 0);
    check("t3_busy_a", busy, 1);
    check("t3_last_a", last_bit, 1);
    check("t3_cdone_a", cmd_done, 1);
    cyc();
    check("t3_busy_b", busy, 1);
    check("t3_idx_b", bit_idx, 0);
    check("t3_first_b", first_bit, 1);
    check("t3_ready_b", ready, 1);
    cyc(); cyc();
    check("t3_idx_b_last", bit_idx, 2);
    check("t3_cdone_b", cmd_done, 1);
    cyc();
    check("t3_idle", busy, 0);
    drain();

    // GAP_BITS=2 instance
    offer(6'd1, 8'd0);
    cyc();
    offer(6'd2, 8'd0);
    cyc();
    cmd_valid = 1'b0;
    #1;
    check("t4_cdone_a", g_cmd_done, 1);
    check("t4_ready_pend", g_ready, 0);
    cyc();
    gap_ticks = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (g_first) break;
      check("t4_gap_busy", g_busy, 1);
      gap_ticks++;
      cyc();
    end
    check("t4_gap_ticks", gap_ticks, 2);
    check("t4_idx_b", g_idx, 0);
    check("t4_ready_b", g_ready, 1);
    drain();

    // Offer in the cmd_done cycle with pending empty
    offer(6'd1, 8'd0);
    cyc();
    cmd_valid = 1'b0;
    cyc();
    offer(6'd0, 8'd0);
    #1;
    check("t5_cdone", cmd_done, 1);
    check("t5_ready", ready, 1);
    cyc();
    cmd_valid = 1'b0;
    #1;
    check("t5_busy", busy, 1);
    check("t5_idx", bit_idx, 0);
    check("t5_first", first_bit, 1);
    check("t5_last", last_bit, 1);
    check("t5_fdone", frame_done, 1);
    check("t5_cdone_c", cmd_done, 1);
    cyc();
    check("t5_idle", busy, 0);
    drain();

    // Reset mid-frame with a pending command
    offer(6'd7, 8'd1);
    cyc();
    offer(6'd5, 8'd0);
    cyc();
    cmd_valid = 1'b0;
    cyc(); cyc();
    check("t6_idx3", bit_idx, 3);
    check("t6_ready_pend", ready, 0);
    check("t6_rep", rep, 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    check("t6_busy", busy, 0);
    check("t6_idx", bit_idx, 0);
    check("t6_rep0", rep, 0);
    check("t6_ready", ready, 1);
    check("t6_first", first_bit, 0);
    check("t6_g_busy", g_busy, 0);
    cyc(); cyc(); cyc();
    check("t6_pend_dropped", busy, 0);

`ifdef TSPI_SEQ_ABORT_EN
    // Abort in the frame-end cycle suppresses the done pulses
    offer(6'd0, 8'd0);
    cyc();
    cmd_valid = 1'b0;
    abort = 1'b1;
    #1;
    check("ab_fdone", frame_done, 0);
    check("ab_cdone", cmd_done, 0);
    check("ab_ready", ready, 0);
    cyc();
    abort = 1'b0;
    #1;
    check("ab_busy", busy, 0);
    check("ab_pulse", aborted, 1);
    cyc();
    check("ab_pulse_end", aborted, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
